// File: rtl/spi_slave_cont_pkg.sv
// spi_slave_cont_pkg: shared frame width, idle byte and FSM encoding for the SPI responder
package spi_slave_cont_pkg;
  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_IDLE_BYTE = 8'hFF;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/spi_slave_cont_sync_edge.sv
// spi_sync_edge: N-flop synchronizer with single-cycle rise/fall pulses
module spi_sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [N-1:0] r_sync;
  logic         r_dly;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_sync <= {N{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
      r_dly  <= r_sync[N-1];
    end
  assign o_q    = r_sync[N-1];
  assign o_rise = o_q & ~r_dly;
  assign o_fall = ~o_q & r_dly;
endmodule

// File: rtl/spi_slave_cont.sv
// spi_slave_cont: oversampled SPI mode-0 responder, MSB first, with a one-deep
// transmit holding register and a strobe per received byte
module spi_slave_cont
  import spi_slave_cont_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = DATA_W'(SPI_IDLE_BYTE)
) (
  input  logic              IN_SCLK,
  input  logic              RST,
  input  logic              W_STB,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_ACK,
  output logic              R_STB,
  output logic [DATA_W-1:0] R_DATA,
  output logic              BUSY,
  input  logic              SPI_SCLK,
  input  logic              SPI_CS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO
);
  localparam int CW = $clog2(DATA_W);
  logic w_sclk, w_sclk_rise, w_sclk_fall, w_cs, w_cs_rise, w_cs_fall, w_mosi;
  logic w_rise, w_last, w_load, w_accept;
  logic [DATA_W-1:0] w_next_tx, w_rx_next;
  state_t r_state;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [DATA_W-2:0] r_rx;
  logic [DATA_W-1:0] r_tx, r_hold, r_rdata;
  logic [CW-1:0] r_bit_cnt;
  logic r_hold_full, r_ack, r_done, r_stb, r_miso;

  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .i_clk(IN_SCLK), .i_rst(RST), .i_d(SPI_SCLK),
    .o_q(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .i_clk(IN_SCLK), .i_rst(RST), .i_d(SPI_CS),
    .o_q(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk_rise & w_sclk;
  assign w_last    = r_bit_cnt == CW'(DATA_W - 1);
  assign w_rx_next = {r_rx, w_mosi};
  assign w_next_tx = r_hold_full ? r_hold : IDLE_BYTE;
  // tx_shift reloads at CS fall and at every frame boundary while selected
  assign w_load    = (r_state == ST_IDLE) ? w_cs_fall
                                          : (w_sclk_fall & (r_bit_cnt == '0) & ~w_cs_rise);
  assign w_accept  = W_STB & (~r_hold_full | w_load);

  always_ff @(posedge IN_SCLK or posedge RST)
    if (RST) begin
      r_state     <= ST_IDLE;
      r_mosi_sync <= '1;
      r_rx        <= '0;
      r_tx        <= IDLE_BYTE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_rdata     <= '0;
      r_bit_cnt   <= '0;
      r_ack       <= 1'b0;
      r_done      <= 1'b0;
      r_stb       <= 1'b0;
      r_miso      <= 1'b1;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      r_ack       <= w_accept;
      r_hold_full <= w_accept | (r_hold_full & ~w_load);
      if (w_accept) r_hold <= W_DATA;
      r_done      <= 1'b0;
      r_stb       <= r_done;
      if (r_state == ST_IDLE) begin
        r_miso <= 1'b1;
        if (w_cs_fall) r_state <= ST_ACTIVE;
      end else begin
        if (w_rise) begin
          r_rx      <= w_rx_next[DATA_W-2:0];
          r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
          if (w_last) begin
            r_rdata <= w_rx_next;
            r_done  <= 1'b1;
          end
        end
        if (w_sclk_fall && r_bit_cnt != '0) begin
          r_tx   <= r_tx << 1;
          r_miso <= r_tx[DATA_W-2];
        end
        if (w_cs_rise) begin
          r_state   <= ST_IDLE;
          r_bit_cnt <= '0;
          r_miso    <= 1'b1;
        end
      end
      if (w_load) begin
        r_tx   <= w_next_tx;
        r_miso <= w_next_tx[DATA_W-1];
      end
    end

  assign W_ACK    = r_ack;
  assign R_STB    = r_stb;
  assign R_DATA   = r_rdata;
  assign BUSY     = ~w_cs;
  assign SPI_MISO = r_miso;
endmodule

// File: tb/tb_spi_slave_cont.sv
// tb_spi_slave_cont: directed SPI controller model with a received-byte scoreboard
module tb_spi_slave_cont;
  localparam int HALF = 60;
  logic clk = 1'b0;
  logic rst, w_stb, sclk, cs, mosi;
  logic [7:0] w_data, r_data;
  logic w_ack, r_stb, busy, miso;
  int n_cmp = 0, n_err = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  spi_slave_cont dut (
    .IN_SCLK(clk), .RST(rst), .W_STB(w_stb), .W_DATA(w_data), .W_ACK(w_ack),
    .R_STB(r_stb), .R_DATA(r_data), .BUSY(busy),
    .SPI_SCLK(sclk), .SPI_CS(cs), .SPI_MOSI(mosi), .SPI_MISO(miso)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && r_stb) begin
      if (rx_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_unexpected: got %0h expected no strobe", r_data);
      end else chk("rx_byte", r_data, rx_q.pop_front());
    end

  task automatic w_write(input logic [7:0] d, input logic exp_ack);
    @(negedge clk);
    w_stb  = 1'b1;
    w_data = d;
    @(negedge clk);
    w_stb = 1'b0;
    chk("w_ack", w_ack, exp_ack);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic wr,
                          input logic [7:0] wd, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      #(HALF);
      got[i] = miso;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
      if (wr && i == 4) w_write(wd, 1'b1);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp_miso,
                          input logic wr = 1'b0, input logic [7:0] wd = 8'h00);
    logic [7:0] got;
    rx_q.push_back(tx);
    spi_bits(tx, 8, wr, wd, got);
    chk("miso_byte", got, exp_miso);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #(HALF);
    cs = 1'b1;
    #100;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] junk;
    rst = 1'b1; w_stb = 1'b0; w_data = 8'h00; sclk = 1'b0; cs = 1'b1; mosi = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_w_ack", w_ack, 0);
    chk("rst_r_stb", r_stb, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miso", miso, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // 1: plain receive, idle byte returned
    cs_low();
    spi_byte(8'hA5, 8'hFF);
    cs_high();
    // 2: queued byte before CS
    w_write(8'h3C, 1'b1);
    cs_low();
    spi_byte(8'h00, 8'h3C);
    cs_high();
    // 3: back-to-back with a byte queued during the first
    cs_low();
    spi_byte(8'h12, 8'hFF, 1'b1, 8'hC3);
    spi_byte(8'h34, 8'hC3);
    cs_high();
    // 4: partial frame discarded, next frame intact
    cs_low();
    spi_bits(8'hF0, 5, 1'b0, 8'h00, junk);
    cs_high();
    cs_low();
    spi_byte(8'h81, 8'hFF);
    cs_high();
    // 5: holding full rejects, reload cycle accepts
    w_write(8'h33, 1'b1);
    w_write(8'h55, 1'b0);
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    w_stb  = 1'b1;
    w_data = 8'h44;
    @(negedge clk);
    w_stb = 1'b0;
    chk("w_ack_reload", w_ack, 1);
    #60;
    spi_byte(8'h09, 8'h33);
    spi_byte(8'h06, 8'h44);
    cs_high();
    // 6: asynchronous reset mid-frame
    cs_low();
    spi_bits(8'hAA, 4, 1'b0, 8'h00, junk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_w_ack", w_ack, 0);
    chk("arst_r_stb", r_stb, 0);
    chk("arst_r_data", r_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_miso", miso, 1);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cs_low();
    chk("busy_active", busy, 1);
    spi_byte(8'h5A, 8'hFF);
    cs_high();
    repeat (20) @(negedge clk);
    chk("rx_drained", rx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
